// File: rtl/hdb3_tx_sequencer_if.sv
// Bundle of the frame handshake, encoder hook-up and status lines of hdb3_tx_sequencer.
// The master side drives the frame; the slave side is the sequencer itself.
interface hdb3_tx_sequencer_if #(
   parameter int WORD_W = 8,
   parameter int LEN_W  = 8
);
   logic              start;
   logic [LEN_W-1:0]  frame_words;
   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              enc_valid;
   logic              origin_data;
   logic              en;
   logic              busy;
   logic              done;
   logic              underrun;
   logic              timeout;

   modport master (
      output start, frame_words, in_data, in_valid, enc_valid,
      input  in_ready, origin_data, en, busy, done, underrun, timeout
   );

   modport slave (
      input  start, frame_words, in_data, in_valid, enc_valid,
      output in_ready, origin_data, en, busy, done, underrun, timeout
   );
endinterface

// File: rtl/hdb3_tx_sequencer.sv
// Frame sequencer feeding an HDB3 encoder: serializes words MSB-first, then flushes
// zeros until the encoder has emitted one symbol per source bit or the flush times out.
module hdb3_tx_sequencer #(
   parameter int WORD_W    = 8,
   parameter int LEN_W     = 8,
   parameter int FLUSH_MAX = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   hdb3_tx_sequencer_if.slave   bus
);
   localparam int TOT_W = LEN_W + $clog2(WORD_W) + 1;
   localparam int BL_W  = $clog2(WORD_W + 1);
   localparam int FC_W  = $clog2(FLUSH_MAX + 1);

   localparam logic [FC_W-1:0] FLUSH_LIM = FC_W'(FLUSH_MAX);
   localparam logic [BL_W-1:0] WORD_BITS = BL_W'(WORD_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic [LEN_W-1:0]  r_words_left;
   logic [TOT_W-1:0]  r_total_bits;
   logic [TOT_W-1:0]  r_out_cnt;
   logic [WORD_W-1:0] r_word;
   logic [BL_W-1:0]   r_bits_left;
   logic [FC_W-1:0]   r_flush_cnt;
   logic              r_stalled;

   logic              r_origin;
   logic              r_en;
   logic              r_busy;
   logic              r_done;
   logic              r_underrun;
   logic              r_timeout;

   logic              w_in_ready;
   logic              w_load;
   logic              w_emit;
   logic              w_last_bit;
   logic              w_stall;
   logic              w_start_go;
   logic              w_start_zero;
   logic [TOT_W-1:0]  w_frame_bits;
   logic [TOT_W-1:0]  w_out_cnt_next;
   logic              w_flush_hit;
   logic              w_flush_to;
   logic              w_flush_exit;

   logic              w_origin_next;
   logic              w_en_next;
   logic              w_busy_next;
   logic              w_done_next;
   logic              w_underrun_next;
   logic              w_timeout_next;

   assign w_start_go   = (r_state == S_IDLE) && bus.start && (bus.frame_words != '0);
   assign w_start_zero = (r_state == S_IDLE) && bus.start && (bus.frame_words == '0);
   assign w_frame_bits = TOT_W'(bus.frame_words) * TOT_W'(WORD_W);

   // Ready while the word register is empty or on its last bit, so back-to-back
   // words stream without a gap on en.
   assign w_in_ready = (r_state == S_SHIFT) && (r_words_left != '0) && (r_bits_left <= BL_W'(1));
   assign w_load     = w_in_ready && bus.in_valid;
   assign w_emit     = (r_state == S_SHIFT) && (r_bits_left != '0);
   assign w_last_bit = w_emit && (r_bits_left == BL_W'(1)) && (r_words_left == '0);
   assign w_stall    = (r_state == S_SHIFT) && (r_bits_left == '0)
                       && (r_words_left != '0) && !w_load;

   // Symbols seen this cycle are counted before the flush exit test.
   assign w_out_cnt_next = ((r_state != S_IDLE) && bus.enc_valid && (r_out_cnt != r_total_bits))
                           ? r_out_cnt + TOT_W'(1) : r_out_cnt;
   assign w_flush_hit  = (w_out_cnt_next == r_total_bits);
   assign w_flush_to   = (r_flush_cnt == FLUSH_LIM);
   assign w_flush_exit = (r_state == S_FLUSH) && (w_flush_hit || w_flush_to);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_start_go)   w_next_state = S_SHIFT;
         S_SHIFT: if (w_last_bit)   w_next_state = S_FLUSH;
         S_FLUSH: if (w_flush_exit) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_origin_next   = 1'b0;
      w_en_next       = 1'b0;
      w_done_next     = w_flush_exit || w_start_zero;
      w_timeout_next  = (r_state == S_FLUSH) && !w_flush_hit && w_flush_to;
      w_underrun_next = w_stall && !r_stalled;
      w_busy_next     = (r_state != S_IDLE) || (w_next_state != S_IDLE);
      if (w_emit) begin
         w_origin_next = r_word[WORD_W-1];
         w_en_next     = 1'b1;
      end else if ((r_state == S_FLUSH) && !w_flush_exit) begin
         w_en_next     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_origin   <= 1'b0;
         r_en       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_origin   <= w_origin_next;
         r_en       <= w_en_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_underrun <= w_underrun_next;
         r_timeout  <= w_timeout_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_words_left <= '0;
         r_total_bits <= '0;
         r_out_cnt    <= '0;
         r_word       <= '0;
         r_bits_left  <= '0;
         r_flush_cnt  <= '0;
         r_stalled    <= 1'b0;
      end else if (w_start_go) begin
         r_words_left <= bus.frame_words;
         r_total_bits <= w_frame_bits;
         r_out_cnt    <= '0;
         r_bits_left  <= '0;
         r_flush_cnt  <= '0;
         r_stalled    <= 1'b0;
      end else begin
         r_out_cnt <= w_out_cnt_next;
         r_stalled <= w_stall;
         // A load on the last bit overwrites the shift; that bit is already registered.
         if (w_load) begin
            r_word       <= bus.in_data;
            r_bits_left  <= WORD_BITS;
            r_words_left <= r_words_left - LEN_W'(1);
         end else if (w_emit) begin
            r_word       <= {r_word[WORD_W-2:0], 1'b0};
            r_bits_left  <= r_bits_left - BL_W'(1);
         end
         if ((r_state == S_FLUSH) && !w_flush_exit) begin
            r_flush_cnt <= r_flush_cnt + FC_W'(1);
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.origin_data = r_origin;
   assign bus.en          = r_en;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.underrun    = r_underrun;
   assign bus.timeout     = r_timeout;
endmodule

// File: tb/tb_hdb3_tx_sequencer.sv
// Directed bench for hdb3_tx_sequencer: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_hdb3_tx_sequencer;
   logic clk;
   logic rst;

   hdb3_tx_sequencer_if #(.WORD_W(8), .LEN_W(8)) bus_if ();

   hdb3_tx_sequencer #(.WORD_W(8), .LEN_W(8), .FLUSH_MAX(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total_cnt = 0;
   int bad_cnt   = 0;

   logic [63:0] obs_bits;
   int obs_en, obs_gap, obs_uf, obs_to, obs_done, obs_done_cyc, obs_busy;
   bit obs_busy_at_done, obs_to_at_done, obs_timed_out;

   // Runs one frame: samples outputs and drives inputs on the falling edge.
   // enc_valid echoes en four cycles late when enc_on is set.
   task automatic run_frame(input int nw, input logic [7:0] w0, input logic [7:0] w1,
                            input int gap, input bit enc_on, input int abort_en,
                            input int restart_cyc);
      int widx, gap_left, post, low_run;
      logic [3:0] hist;
      bit seen_en, seen_done, aborted;
      obs_bits = '0; obs_en = 0; obs_gap = 0; obs_uf = 0; obs_to = 0;
      obs_done = 0; obs_done_cyc = 0; obs_busy = 0;
      obs_busy_at_done = 0; obs_to_at_done = 0; obs_timed_out = 0;
      widx = 0; gap_left = gap; post = 0; low_run = 0; hist = '0;
      seen_en = 0; seen_done = 0; aborted = 0;
      @(negedge clk);
      bus_if.start       = 1'b1;
      bus_if.frame_words = 8'(nw);
      bus_if.in_valid    = (nw > 0);
      bus_if.in_data     = w0;
      bus_if.enc_valid   = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         bus_if.start = (k == restart_cyc);
         bus_if.frame_words = (k == restart_cyc) ? 8'd3 : 8'(nw);
         if (bus_if.en) begin
            obs_bits = {obs_bits[62:0], bus_if.origin_data};
            obs_en++;
            if (seen_en) obs_gap += low_run;
            low_run = 0;
            seen_en = 1;
         end else if (seen_en) begin
            low_run++;
         end
         if (bus_if.underrun) obs_uf++;
         if (bus_if.timeout) obs_to++;
         if (bus_if.busy) obs_busy++;
         if (bus_if.done) begin
            obs_done++;
            if (!seen_done) begin
               obs_done_cyc     = k;
               obs_busy_at_done = bus_if.busy;
               obs_to_at_done   = bus_if.timeout;
            end
            seen_done = 1;
         end
         if (abort_en != 0 && obs_en == abort_en) begin
            aborted = 1;
            break;
         end
         if (seen_done) begin
            post++;
            if (post > 6) break;
         end
         bus_if.enc_valid = enc_on & hist[3];
         hist = {hist[2:0], bus_if.en};
         if (widx < nw) begin
            bus_if.in_data = (widx == 0) ? w0 : w1;
            if (widx == 1 && gap_left > 0 && bus_if.in_ready) begin
               bus_if.in_valid = 1'b0;
               gap_left--;
            end else begin
               bus_if.in_valid = 1'b1;
               if (bus_if.in_ready) widx++;
            end
         end else begin
            bus_if.in_valid = 1'b0;
         end
      end
      if (!seen_done && !aborted) obs_timed_out = 1;
      bus_if.start     = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.enc_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus_if.start = 1'b0; bus_if.frame_words = '0; bus_if.in_data = '0;
      bus_if.in_valid = 1'b0; bus_if.enc_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total_cnt++;
      if ({bus_if.origin_data, bus_if.en, bus_if.busy, bus_if.done} !== 4'b0) begin
         bad_cnt++;
         $display("FAIL reset_out: got od/en/busy/done=%b want 0000",
                  {bus_if.origin_data, bus_if.en, bus_if.busy, bus_if.done});
      end
      total_cnt++;
      if ({bus_if.underrun, bus_if.timeout, bus_if.in_ready} !== 3'b0) begin
         bad_cnt++;
         $display("FAIL reset_flags: got uf/to/rdy=%b want 000",
                  {bus_if.underrun, bus_if.timeout, bus_if.in_ready});
      end
      rst = 1'b1;
      $display("test_reset: checked");
   endtask

   task automatic test_continuous();
      run_frame(2, 8'hA5, 8'h3C, 0, 1'b1, 0, 0);
      total_cnt++;
      if (obs_bits !== 64'hA53C0) begin
         bad_cnt++; $display("FAIL cont_bits: got %h want a53c0", obs_bits);
      end
      total_cnt++;
      if (obs_en !== 20) begin
         bad_cnt++; $display("FAIL cont_en_cycles: got %0d want 20", obs_en);
      end
      total_cnt++;
      if (obs_gap !== 0 || obs_uf !== 0) begin
         bad_cnt++; $display("FAIL cont_gap_uf: got gap=%0d uf=%0d want 0 0", obs_gap, obs_uf);
      end
      total_cnt++;
      if (obs_done !== 1 || obs_done_cyc !== 23 || obs_timed_out) begin
         bad_cnt++; $display("FAIL cont_done: got n=%0d cyc=%0d want 1 at 23", obs_done, obs_done_cyc);
      end
      total_cnt++;
      if (obs_busy !== 23 || !obs_busy_at_done || obs_to !== 0) begin
         bad_cnt++; $display("FAIL cont_busy: got busy=%0d at_done=%0d to=%0d want 23 1 0",
                             obs_busy, obs_busy_at_done, obs_to);
      end
      $display("test_continuous: bits=%h en=%0d done_cyc=%0d", obs_bits, obs_en, obs_done_cyc);
   endtask

   task automatic test_stall();
      run_frame(2, 8'hA5, 8'h3C, 3, 1'b1, 0, 0);
      total_cnt++;
      if (obs_bits !== 64'hA53C0) begin
         bad_cnt++; $display("FAIL stall_bits: got %h want a53c0", obs_bits);
      end
      total_cnt++;
      if (obs_gap !== 3) begin
         bad_cnt++; $display("FAIL stall_gap: got %0d want 3", obs_gap);
      end
      total_cnt++;
      if (obs_uf !== 1) begin
         bad_cnt++; $display("FAIL stall_underrun: got %0d want 1", obs_uf);
      end
      total_cnt++;
      if (obs_done !== 1 || obs_done_cyc !== 26 || obs_busy !== 26) begin
         bad_cnt++; $display("FAIL stall_done: got n=%0d cyc=%0d busy=%0d want 1 26 26",
                             obs_done, obs_done_cyc, obs_busy);
      end
      $display("test_stall: gap=%0d uf=%0d done_cyc=%0d", obs_gap, obs_uf, obs_done_cyc);
   endtask

   task automatic test_zero_length();
      bit en_seen, busy_seen;
      en_seen = 0; busy_seen = 0;
      @(negedge clk);
      bus_if.start = 1'b1; bus_if.frame_words = 8'd0;
      @(negedge clk);
      bus_if.start = 1'b0;
      total_cnt++;
      if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0) begin
         bad_cnt++; $display("FAIL zero_done: got done=%b busy=%b want 1 0", bus_if.done, bus_if.busy);
      end
      en_seen = bus_if.en;
      @(negedge clk);
      total_cnt++;
      if (bus_if.done !== 1'b0) begin
         bad_cnt++; $display("FAIL zero_pulse: got done=%b want 0", bus_if.done);
      end
      for (int i = 0; i < 4; i++) begin
         if (bus_if.en) en_seen = 1;
         if (bus_if.busy) busy_seen = 1;
         @(negedge clk);
      end
      total_cnt++;
      if (en_seen || busy_seen) begin
         bad_cnt++; $display("FAIL zero_quiet: got en=%b busy=%b want 0 0", en_seen, busy_seen);
      end
      $display("test_zero_length: en=%b busy=%b", en_seen, busy_seen);
   endtask

   task automatic test_timeout();
      run_frame(1, 8'h5A, 8'h00, 0, 1'b0, 0, 0);
      total_cnt++;
      if (obs_bits !== 64'h5A0000 || obs_en !== 24) begin
         bad_cnt++; $display("FAIL to_en: got bits=%h en=%0d want 5a0000 24", obs_bits, obs_en);
      end
      total_cnt++;
      if (obs_done !== 1 || obs_done_cyc !== 27 || !obs_to_at_done || obs_to !== 1) begin
         bad_cnt++; $display("FAIL to_done: got n=%0d cyc=%0d to_at_done=%0d to=%0d want 1 27 1 1",
                             obs_done, obs_done_cyc, obs_to_at_done, obs_to);
      end
      $display("test_timeout: en=%0d done_cyc=%0d to=%0d", obs_en, obs_done_cyc, obs_to);
   endtask

   task automatic test_reset_mid_frame();
      bit done_seen, busy_seen;
      done_seen = 0; busy_seen = 0;
      run_frame(2, 8'hA5, 8'h3C, 0, 1'b1, 6, 0);
      total_cnt++;
      if (obs_bits !== 64'h29) begin
         bad_cnt++; $display("FAIL rmid_prefix: got %h want 29", obs_bits);
      end
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if ({bus_if.origin_data, bus_if.en, bus_if.busy, bus_if.done,
           bus_if.underrun, bus_if.timeout, bus_if.in_ready} !== 7'b0) begin
         bad_cnt++; $display("FAIL rmid_async: got %b want 0000000",
                             {bus_if.origin_data, bus_if.en, bus_if.busy, bus_if.done,
                              bus_if.underrun, bus_if.timeout, bus_if.in_ready});
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus_if.done) done_seen = 1;
         if (bus_if.busy || bus_if.en) busy_seen = 1;
      end
      total_cnt++;
      if (done_seen || busy_seen) begin
         bad_cnt++; $display("FAIL rmid_idle: got done=%b busy/en=%b want 0 0", done_seen, busy_seen);
      end
      run_frame(2, 8'hA5, 8'h3C, 0, 1'b1, 0, 0);
      total_cnt++;
      if (obs_bits !== 64'hA53C0 || obs_done !== 1 || obs_done_cyc !== 23) begin
         bad_cnt++; $display("FAIL rmid_next: got bits=%h n=%0d cyc=%0d want a53c0 1 23",
                             obs_bits, obs_done, obs_done_cyc);
      end
      $display("test_reset_mid_frame: next frame bits=%h", obs_bits);
   endtask

   task automatic test_start_while_busy();
      run_frame(2, 8'hA5, 8'h3C, 0, 1'b1, 0, 5);
      total_cnt++;
      if (obs_bits !== 64'hA53C0 || obs_en !== 20) begin
         bad_cnt++; $display("FAIL busy_start_bits: got bits=%h en=%0d want a53c0 20", obs_bits, obs_en);
      end
      total_cnt++;
      if (obs_done !== 1 || obs_done_cyc !== 23 || obs_busy !== 23) begin
         bad_cnt++; $display("FAIL busy_start_done: got n=%0d cyc=%0d busy=%0d want 1 23 23",
                             obs_done, obs_done_cyc, obs_busy);
      end
      $display("test_start_while_busy: done=%0d", obs_done);
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_stall();
      test_zero_length();
      test_timeout();
      test_reset_mid_frame();
      test_start_while_busy();
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end
endmodule
